// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel RAM loader and its companion stages.
package pixel_pkg;

    // Default geometry of the 4096x32 pixel RAM.
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LEN_W  = 15;

    // Byte-lane index within one RAM word.
    typedef logic [$clog2(LANES)-1:0] lane_t;

    // Loader sequencing states; fixed encodings keep the legacy state values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/lane_addr_ptr.sv
// Lane/word write pointer: lane steps every increment, word address steps
// when the lane rolls over from its last value, address wraps at the top.
module lane_addr_ptr #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [LANE_W-1:0] lane,
    output logic [ADDR_W-1:0] addr
);
    import pixel_pkg::*;

    // Pointer register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= '0;
            addr <= '0;
        end else if (inc) begin
            if (lane == '1) begin
                lane <= '0;
                addr <= addr + ADDR_W'(1);
            end else begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_loader.sv
// Pixel RAM loader: packs a valid/ready pixel stream into byte-lane writes,
// zero-pads a partial final word and pulses done once per frame.
module pixel_loader #(
    parameter int unsigned ADDR_W = pixel_pkg::ADDR_W,
    parameter int unsigned PIX_W  = pixel_pkg::PIX_W,
    parameter int unsigned LANES  = pixel_pkg::LANES,
    parameter int unsigned LEN_W  = pixel_pkg::LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     ram_wr_en,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [$clog2(LANES)-1:0] ram_lane,
    output logic [PIX_W-1:0]         ram_wr_data,
    output logic                     busy,
    output logic                     done
);
    import pixel_pkg::*;

    localparam int unsigned       LANE_W    = $clog2(LANES);
    localparam int unsigned       MAX_FRAME = LANES << ADDR_W;
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_FRAME);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    loader_state_t     state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rcvd;
    logic [LEN_W-1:0]  len_clamped;
    logic [LANE_W-1:0] ptr_lane;
    logic [ADDR_W-1:0] ptr_addr;
    logic              ptr_clear;
    logic              ptr_inc;
    logic              xfer;
    logic              last_pix;

    // Handshake decode, frame length clamp and pointer controls.
    always_comb begin
        xfer        = pix_valid & pix_ready;
        last_pix    = (rcvd + LEN_W'(1)) == len_q;
        len_clamped = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
        ptr_clear   = (state == IDLE) && start;
        ptr_inc     = xfer || (state == PAD);
    end

    lane_addr_ptr #(
        .ADDR_W(ADDR_W),
        .LANE_W(LANE_W)
    ) u_ptr (
        .clk  (clk),
        .rst  (rst),
        .clear(ptr_clear),
        .inc  (ptr_inc),
        .lane (ptr_lane),
        .addr (ptr_addr)
    );

    // Frame sequencer and registered RAM-side outputs.
    // DONE covers the cycle the final write is presented; done/busy change on
    // leaving it. A zero-length frame has no write to wait for, so it pulses
    // done straight from IDLE, which keeps the pulse one cycle after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            rcvd        <= '0;
            pix_ready   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr    <= '0;
            ram_lane    <= '0;
            ram_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len_clamped;
                        rcvd  <= '0;
                        if (len_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            pix_ready <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_data <= pix_data;
                        ram_addr    <= ptr_addr;
                        ram_lane    <= ptr_lane;
                        rcvd        <= rcvd + LEN_W'(1);
                        if (last_pix) begin
                            pix_ready <= 1'b0;
                            state     <= (ptr_lane == LAST_LANE) ? DONE : PAD;
                        end
                    end
                end
                PAD: begin
                    ram_wr_en   <= 1'b1;
                    ram_wr_data <= '0;
                    ram_addr    <= ptr_addr;
                    ram_lane    <= ptr_lane;
                    if (ptr_lane == LAST_LANE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
// Scoreboard bench for pixel_loader: stimulus queues expected RAM writes and
// done pulses; a negedge monitor pops and compares them as they appear.
module tb_pixel_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] frame_len;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        ram_wr_en;
    logic [11:0] ram_addr;
    logic [1:0]  ram_lane;
    logic [7:0]  ram_wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [21:0] wq[$];
    bit          dq[$];

    always #5 clk = ~clk;

    pixel_loader #(
        .ADDR_W(12),
        .PIX_W (8),
        .LANES (4),
        .LEN_W (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .ram_wr_en  (ram_wr_en),
        .ram_addr   (ram_addr),
        .ram_lane   (ram_lane),
        .ram_wr_data(ram_wr_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int unsigned addr, input int unsigned lane, input int unsigned data);
        logic [11:0] a;
        logic [1:0]  l;
        logic [7:0]  d;
        a = 12'(addr);
        l = 2'(lane);
        d = 8'(data);
        wq.push_back({a, l, d});
    endtask

    task automatic start_frame(input int unsigned len);
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = 15'(len);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Holds a pixel valid until it is taken; returns 1 ns after the accepting edge.
    task automatic send_pix(input logic [7:0] d);
        int unsigned budget;
        logic got;
        budget    = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        do begin
            got = pix_ready;
            @(posedge clk); #1;
            budget++;
        end while (!got && budget < 50);
        check($sformatf("accept_pix_%0h", d), {31'd0, got}, 32'd1);
    endtask

    task automatic idle_cycles(input int unsigned n);
        pix_valid = 1'b0;
        pix_data  = 8'hFF;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_not_busy();
        int unsigned budget;
        budget = 0;
        while (busy && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("frame_completes", {31'd0, busy}, 32'd0);
        idle_cycles(3);
    endtask

    // Monitor: every write and done pulse must match the head of its queue.
    initial begin
        logic [21:0] e;
        bit          ep;
        logic        prev_wr;
        int          wr_idx;
        prev_wr = 1'b0;
        wr_idx  = 0;
        forever begin
            @(negedge clk);
            if (ram_wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d lane %0d data 0x%0h, required no write",
                             ram_addr, ram_lane, ram_wr_data);
                end else begin
                    e = wq.pop_front();
                    check($sformatf("write_%0d", wr_idx), {10'd0, ram_addr, ram_lane, ram_wr_data}, {10'd0, e});
                end
                wr_idx++;
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, required done=0");
                end else begin
                    ep = dq.pop_front();
                    check("done_after_last_write", {31'd0, prev_wr}, {31'd0, ep});
                    check("busy_low_with_done", {31'd0, busy}, 32'd0);
                    check("writes_pending_at_done", 32'(wq.size()), 32'd0);
                end
            end
            prev_wr = ram_wr_en;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, pix_ready, ram_wr_en, busy, done, ram_addr, ram_lane, ram_wr_data} & 32'h1FFF_FFFF,
              32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: full words, back-to-back.
        for (int i = 0; i < 8; i++) push_wr(i / 4, i % 4, i + 1);
        dq.push_back(1'b1);
        start_frame(8);
        check("t1_ready_in_load", {30'd0, pix_ready, busy}, 32'd3);
        for (int i = 0; i < 8; i++) send_pix(8'(i + 1));
        pix_valid = 1'b0;
        wait_not_busy();

        // 2: partial last word, pixel held valid during padding.
        push_wr(0, 0, 8'hA0); push_wr(0, 1, 8'hA1); push_wr(0, 2, 8'hA2); push_wr(0, 3, 8'hA3);
        push_wr(1, 0, 8'hA4); push_wr(1, 1, 0); push_wr(1, 2, 0); push_wr(1, 3, 0);
        dq.push_back(1'b1);
        start_frame(5);
        for (int i = 0; i < 5; i++) send_pix(8'(8'hA0 + i));
        pix_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_pad_blocked_%0d", k), {30'd0, pix_ready, busy}, 32'd1);
            @(posedge clk); #1;
        end
        wait_not_busy();

        // 3: valid toggling 1,0,0; outputs hold between writes.
        for (int i = 0; i < 6; i++) push_wr(i / 4, i % 4, 8'h31 + i);
        push_wr(1, 2, 0); push_wr(1, 3, 0);
        dq.push_back(1'b1);
        start_frame(6);
        for (int i = 0; i < 6; i++) begin
            send_pix(8'(8'h31 + i));
            pix_valid = 1'b0;
            pix_data  = 8'hFF;
            @(posedge clk); #1;
            if (i < 5) begin
                check($sformatf("t3_hold_%0d", i), {9'd0, ram_wr_en, ram_addr, ram_lane, ram_wr_data},
                      {9'd0, 1'b0, 12'(i / 4), 2'(i % 4), 8'(8'h31 + i)});
            end
            @(posedge clk); #1;
        end
        wait_not_busy();

        // 4a: zero-length frame.
        dq.push_back(1'b0);
        start_frame(0);
        check("t4_zero_done", {30'd0, done, busy}, 32'd2);
        idle_cycles(3);

        // 4b: start while busy is ignored.
        for (int i = 0; i < 4; i++) push_wr(0, i, 8'hC0 + i);
        dq.push_back(1'b1);
        start_frame(4);
        send_pix(8'hC0);
        send_pix(8'hC1);
        start     = 1'b1;
        frame_len = 15'd8;
        send_pix(8'hC2);
        start     = 1'b0;
        send_pix(8'hC3);
        pix_valid = 1'b0;
        wait_not_busy();

        // 5: reset mid-frame, then restart.
        for (int i = 0; i < 3; i++) push_wr(0, i, 8'h41 + i);
        start_frame(8);
        for (int i = 0; i < 3; i++) send_pix(8'(8'h41 + i));
        rst       = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_reset_outputs", {19'd0, pix_ready, ram_wr_en, busy, done, ram_addr, ram_lane, ram_wr_data}, 32'd0);
        rst = 1'b0;
        idle_cycles(5);
        for (int i = 0; i < 4; i++) push_wr(0, i, 8'h51 + i);
        dq.push_back(1'b1);
        start_frame(4);
        for (int i = 0; i < 4; i++) send_pix(8'(8'h51 + i));
        pix_valid = 1'b0;
        wait_not_busy();

        // 6: oversize length clamps to the full RAM.
        for (int i = 0; i < 16384; i++) push_wr(i / 4, i % 4, i % 256);
        dq.push_back(1'b1);
        start_frame(20000);
        for (int i = 0; i < 16384; i++) send_pix(8'(i));
        check("t6_last_write", {17'd0, ram_wr_en, pix_ready, ram_addr, ram_lane}, {17'd0, 1'b1, 1'b0, 12'd4095, 2'd3});
        repeat (3) begin
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        wait_not_busy();

        idle_cycles(5);
        check("writes_all_seen", 32'(wq.size()), 32'd0);
        check("dones_all_seen", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
